// File: rtl/ecc_secded_pipe.sv
// Two-stage pipelined SEC-DED decoder: stage 1 classifies the beat, stage 2 corrects it and
// re-encodes the check bits. Single valid/ready advance and saturating error counters.
module ecc_secded_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned R = (DATA_W <= 4)  ? 3 :
                                (DATA_W <= 11) ? 4 :
                                (DATA_W <= 26) ? 5 :
                                (DATA_W <= 57) ? 6 : 7,
    localparam int unsigned CW = R + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              corr_en,
    input  logic              cnt_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW-1:0]     in_chk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_chk,
    output logic              err_ce,
    output logic              err_ue,
    output logic [R-1:0]      err_syn,
    output logic [CNT_W-1:0]  cnt_ce,
    output logic [CNT_W-1:0]  cnt_ue
);

    localparam int unsigned N = DATA_W + R;

    // Codeword position of data bit j: the j-th non-power-of-two position from 3 upwards.
    function automatic int unsigned data_pos(int unsigned j);
        int unsigned k;
        int unsigned p;
        k = 0;
        p = 0;
        for (int unsigned q = 3; q <= N; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (k == j) p = q;
                k++;
            end
        end
        return p;
    endfunction

    function automatic logic [R-1:0] ham(logic [DATA_W-1:0] d);
        logic [R-1:0] h;
        int unsigned  p;
        h = '0;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            p = data_pos(j);
            for (int unsigned i = 0; i < R; i++) begin
                if (((p >> i) & 1) != 0) h[i] = h[i] ^ d[j];
            end
        end
        return h;
    endfunction

    function automatic logic [CW-1:0] encode(logic [DATA_W-1:0] d);
        logic [R-1:0] h;
        h = ham(d);
        return {^{d, h}, h};
    endfunction

    logic              adv;
    logic              hs_out;

    logic [R-1:0]      syn_d;
    logic              par_e;
    logic              ce_d;
    logic              ue_d;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [R-1:0]      s1_syn_q;
    logic              s1_ce_q;
    logic              s1_ue_q;
    logic              s1_corr_q;

    logic [DATA_W-1:0] cor_d;
    logic [CW-1:0]     chk_d;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CW-1:0]     out_chk_q;
    logic              err_ce_q;
    logic              err_ue_q;
    logic [R-1:0]      err_syn_q;
    logic [CNT_W-1:0]  cnt_ce_q;
    logic [CNT_W-1:0]  cnt_ue_q;

    assign adv    = !out_valid_q || out_ready;
    assign hs_out = out_valid_q && out_ready;

    always_comb begin
        syn_d = ham(in_data) ^ in_chk[R-1:0];
        par_e = ^{in_data, in_chk};
        ce_d  = 1'b0;
        ue_d  = 1'b0;
        if (syn_d == '0) begin
            ce_d = par_e;
        end else if (!par_e) begin
            ue_d = 1'b1;
        end else if (32'(syn_d) <= N) begin
            ce_d = 1'b1;
        end else begin
            ue_d = 1'b1;
        end
    end

    // Only data positions flip; a syndrome pointing at a check bit leaves data untouched.
    always_comb begin
        cor_d = s1_data_q;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            if (s1_corr_q && s1_ce_q && (s1_syn_q == R'(data_pos(j)))) begin
                cor_d[j] = !s1_data_q[j];
            end
        end
        chk_d = encode(cor_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_syn_q    <= '0;
            s1_ce_q     <= 1'b0;
            s1_ue_q     <= 1'b0;
            s1_corr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chk_q   <= '0;
            err_ce_q    <= 1'b0;
            err_ue_q    <= 1'b0;
            err_syn_q   <= '0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            s1_data_q   <= in_data;
            s1_syn_q    <= syn_d;
            s1_ce_q     <= ce_d;
            s1_ue_q     <= ue_d;
            s1_corr_q   <= corr_en;
            out_valid_q <= s1_valid_q;
            out_data_q  <= cor_d;
            out_chk_q   <= chk_d;
            err_ce_q    <= s1_valid_q && s1_ce_q;
            err_ue_q    <= s1_valid_q && s1_ue_q;
            err_syn_q   <= s1_syn_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_ce_q <= '0;
            cnt_ue_q <= '0;
        end else begin
            if (hs_out && err_ce_q && (cnt_ce_q != '1)) cnt_ce_q <= cnt_ce_q + 1'b1;
            if (hs_out && err_ue_q && (cnt_ue_q != '1)) cnt_ue_q <= cnt_ue_q + 1'b1;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chk   = out_chk_q;
    assign err_ce    = err_ce_q;
    assign err_ue    = err_ue_q;
    assign err_syn   = err_syn_q;
    assign cnt_ce    = cnt_ce_q;
    assign cnt_ue    = cnt_ue_q;

endmodule
